// File: rtl/dbg_apb_master.sv
// dbg_apb_master: turns valid/ready debug requests into single APB transfers,
// returning read data or a timeout error on a valid/ready response channel.
module dbg_apb_master #(
   parameter int ADDR_WIDTH     = 5,
   parameter int WDATA_WIDTH    = 32,
   parameter int RDATA_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_wr_rd,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [WDATA_WIDTH-1:0] req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [RDATA_WIDTH-1:0] rsp_rdata,
   output logic                   rsp_err,
   output logic [ADDR_WIDTH-1:0]  apb_addr,
   output logic                   apb_sel,
   output logic                   apb_enable,
   output logic                   apb_wr_rd,
   output logic [WDATA_WIDTH-1:0] apb_wdata,
   input  logic                   apb_ready,
   input  logic [RDATA_WIDTH-1:0] apb_rdata
);
   // a disabled timeout still keeps a 1-bit counter so no zero-width vector appears
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                 state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic                   sel_nx, en_nx, wr_nx, rv_nx, err_nx, timeout;
   logic [ADDR_WIDTH-1:0]  addr_nx;
   logic [WDATA_WIDTH-1:0] wdata_nx;
   logic [RDATA_WIDTH-1:0] rdata_nx;

   assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
   assign req_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (req_valid && req_ready) ? SETUP : IDLE;
         SETUP:   state_nx = ACCESS;
         ACCESS:  state_nx = (apb_ready || timeout) ? RESP : ACCESS;
         RESP:    state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   // next values of the registered outputs; ready beats a coincident timeout
   always_comb begin
      sel_nx   = apb_sel;
      en_nx    = apb_enable;
      wr_nx    = apb_wr_rd;
      addr_nx  = apb_addr;
      wdata_nx = apb_wdata;
      rv_nx    = rsp_valid;
      err_nx   = rsp_err;
      rdata_nx = rsp_rdata;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (req_valid && req_ready) begin
            sel_nx   = 1'b1;
            en_nx    = 1'b0;
            wr_nx    = req_wr_rd;
            addr_nx  = req_addr;
            wdata_nx = req_wdata;
         end
         SETUP: begin
            en_nx  = 1'b1;
            cnt_nx = '0;
         end
         ACCESS: if (apb_ready || timeout) begin
            sel_nx   = 1'b0;
            en_nx    = 1'b0;
            rv_nx    = 1'b1;
            err_nx   = !apb_ready;
            rdata_nx = (apb_ready && !apb_wr_rd) ? apb_rdata : '0;
         end else begin
            cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;
         end
         RESP: if (rsp_ready) rv_nx = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         apb_sel    <= 1'b0;
         apb_enable <= 1'b0;
         apb_wr_rd  <= 1'b0;
         apb_addr   <= '0;
         apb_wdata  <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
         cnt        <= '0;
      end else begin
         apb_sel    <= sel_nx;
         apb_enable <= en_nx;
         apb_wr_rd  <= wr_nx;
         apb_addr   <= addr_nx;
         apb_wdata  <= wdata_nx;
         rsp_valid  <= rv_nx;
         rsp_err    <= err_nx;
         rsp_rdata  <= rdata_nx;
         cnt        <= cnt_nx;
      end
   end
endmodule
